// File: rtl/ascon_stream_driver.sv
// ascon_stream_driver: initiator-side sequencer for the Ascon core streaming
// interface. The host preloads AD/data blocks into an input buffer and issues
// run_i; the driver pulses the core start, feeds the blocks under valid/ready,
// captures output blocks and the tag, and compares the tag on decryption.
//
// Optional build macro: ASCON_DRV_WATCHDOG_EN adds a WDOG_WIDTH-bit
// inactivity watchdog and the err_timeout_o output.
module ascon_stream_driver #(
    parameter int BLOCK_WIDTH = 64,
    parameter int TAG_WIDTH   = 128,
    parameter int DEPTH       = 32,
    parameter int AW          = $clog2(DEPTH)
`ifdef ASCON_DRV_WATCHDOG_EN
    ,
    parameter int WDOG_WIDTH  = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    // host side: input buffer write port
    input  logic                   wr_en_i,
    input  logic [AW-1:0]          wr_addr_i,
    input  logic [BLOCK_WIDTH-1:0] wr_data_i,
    // host side: output buffer read port
    input  logic [AW-1:0]          rd_addr_i,
    output logic [BLOCK_WIDTH-1:0] rd_data_o,
    // host side: command
    input  logic                   run_i,
    input  logic                   decrypt_i,
    input  logic [AW:0]            n_blk_i,
    input  logic [TAG_WIDTH-1:0]   exp_tag_i,
    // core side
    output logic                   core_start_o,
    output logic [BLOCK_WIDTH-1:0] core_data_o,
    output logic                   core_data_valid_o,
    input  logic                   core_data_ready_i,
    input  logic [BLOCK_WIDTH-1:0] core_data_i,
    input  logic                   core_data_valid_i,
    input  logic [TAG_WIDTH-1:0]   core_tag_i,
    input  logic                   core_tag_valid_i,
    input  logic                   core_done_i,
    // status
    output logic                   busy_o,
    output logic                   done_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic                   auth_ok_o,
    output logic [AW:0]            out_cnt_o,
`ifdef ASCON_DRV_WATCHDOG_EN
    output logic                   err_timeout_o,
`endif
    output logic                   err_ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]            n_blk_q, n_blk_d;
    logic [AW:0]            out_cnt_q, out_cnt_d;
    logic                   decrypt_q, decrypt_d;
    logic [TAG_WIDTH-1:0]   exp_tag_q, exp_tag_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   auth_ok_q, auth_ok_d;
    logic                   err_ovf_q, err_ovf_d;
    logic [BLOCK_WIDTH-1:0] rd_data_q;

    logic [BLOCK_WIDTH-1:0] inbuf  [DEPTH];
    logic [BLOCK_WIDTH-1:0] outbuf [DEPTH];

    logic                   active;
    logic                   run_accept;
    logic                   in_we;
    logic                   out_we;
    logic                   xfer;
    logic [AW:0]            ptr_inc;

`ifdef ASCON_DRV_WATCHDOG_EN
    logic [WDOG_WIDTH-1:0]  wdog_q, wdog_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   activity;
`endif

    // Qualifiers shared by the FSM, the buffers and the capture logic.
    always_comb begin
        active     = (state_q != S_IDLE);
        run_accept = (state_q == S_IDLE) && run_i;
        in_we      = (state_q == S_IDLE) && wr_en_i;
        // out_cnt never exceeds DEPTH, so its MSB alone flags a full buffer
        out_we     = active && core_data_valid_i && !out_cnt_q[AW];
        xfer       = (state_q == S_FEED) && core_data_ready_i;
        ptr_inc    = rd_ptr_q + 1'b1;
`ifdef ASCON_DRV_WATCHDOG_EN
        activity   = core_data_valid_i || core_tag_valid_i || core_done_i || xfer;
`endif
    end

    // Next-state logic: sequencing, command latch, output and tag capture.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        n_blk_d   = n_blk_q;
        out_cnt_d = out_cnt_q;
        decrypt_d = decrypt_q;
        exp_tag_d = exp_tag_q;
        tag_d     = tag_q;
        auth_ok_d = auth_ok_q;
        err_ovf_d = err_ovf_q;
`ifdef ASCON_DRV_WATCHDOG_EN
        wdog_d        = wdog_q;
        err_timeout_d = err_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    decrypt_d = decrypt_i;
                    n_blk_d   = n_blk_i;
                    exp_tag_d = exp_tag_i;
                    out_cnt_d = '0;
                    err_ovf_d = 1'b0;
                    auth_ok_d = 1'b0;
                    tag_d     = '0;
                    rd_ptr_d  = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                state_d = (n_blk_q != '0) ? S_FEED : S_WAIT;
            end
            S_FEED: begin
                if (xfer) begin
                    rd_ptr_d = ptr_inc;
                    if (ptr_inc == n_blk_q) begin
                        state_d = S_WAIT;
                    end
                end
                // a premature done abandons whatever is left to feed
                if (core_done_i) begin
                    state_d = S_DONE;
                end
            end
            S_WAIT: begin
                if (core_done_i) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (active) begin
            if (core_data_valid_i) begin
                if (!out_cnt_q[AW]) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end else begin
                    err_ovf_d = 1'b1;
                end
            end
            if (core_tag_valid_i) begin
                tag_d     = core_tag_i;
                auth_ok_d = decrypt_q && (core_tag_i == exp_tag_q);
            end
        end

`ifdef ASCON_DRV_WATCHDOG_EN
        if (run_accept) begin
            wdog_d        = '1;
            err_timeout_d = 1'b0;
        end else if (active && activity) begin
            wdog_d = '1;
        end else if ((state_q == S_FEED) || (state_q == S_WAIT)) begin
            if (wdog_q == '0) begin
                state_d       = S_DONE;
                err_timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q - 1'b1;
            end
        end
`endif
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            n_blk_q   <= '0;
            out_cnt_q <= '0;
            decrypt_q <= 1'b0;
            exp_tag_q <= '0;
            tag_q     <= '0;
            auth_ok_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            n_blk_q   <= n_blk_d;
            out_cnt_q <= out_cnt_d;
            decrypt_q <= decrypt_d;
            exp_tag_q <= exp_tag_d;
            tag_q     <= tag_d;
            auth_ok_q <= auth_ok_d;
            err_ovf_q <= err_ovf_d;
        end
    end

`ifdef ASCON_DRV_WATCHDOG_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q        <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout_o = err_timeout_q;
`endif

    // Input buffer: host writes, accepted only while idle.
    always_ff @(posedge clk) begin
        if (in_we) begin
            inbuf[wr_addr_i] <= wr_data_i;
        end
    end

    // Output buffer: core output blocks, stored in arrival order.
    always_ff @(posedge clk) begin
        if (out_we) begin
            outbuf[out_cnt_q[AW-1:0]] <= core_data_i;
        end
    end

    // Registered host read port of the output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= outbuf[rd_addr_i];
        end
    end

    assign core_start_o      = (state_q == S_START);
    assign core_data_valid_o = (state_q == S_FEED);
    assign core_data_o       = core_data_valid_o ? inbuf[rd_ptr_q[AW-1:0]] : '0;
    assign busy_o            = (state_q == S_START) || (state_q == S_FEED) ||
                               (state_q == S_WAIT);
    assign done_o            = (state_q == S_DONE);
    assign tag_o             = tag_q;
    assign auth_ok_o         = auth_ok_q;
    assign out_cnt_o         = out_cnt_q;
    assign err_ovf_o         = err_ovf_q;
    assign rd_data_o         = rd_data_q;

endmodule

// File: tb/tb_ascon_stream_driver.sv
// Self-checking bench for ascon_stream_driver: the bench plays both host and
// core, keeps scoreboards of expected fed blocks and expected captured blocks.
module tb_ascon_stream_driver;

    localparam int BW    = 64;
    localparam int TW    = 128;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam logic [TW-1:0] KTAG = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic          clk, rst;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i, rd_addr_i;
    logic [BW-1:0] wr_data_i, rd_data_o;
    logic          run_i, decrypt_i;
    logic [AW:0]   n_blk_i;
    logic [TW-1:0] exp_tag_i;
    logic          core_start_o, core_data_valid_o, core_data_ready_i;
    logic [BW-1:0] core_data_o, core_data_i;
    logic          core_data_valid_i, core_tag_valid_i, core_done_i;
    logic [TW-1:0] core_tag_i, tag_o;
    logic          busy_o, done_o, auth_ok_o, err_ovf_o;
    logic [AW:0]   out_cnt_o;
`ifdef ASCON_DRV_WATCHDOG_EN
    logic          err_timeout_o;
`endif

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int          cyc = 0;
    int          valid_cycles = 0;

    logic [BW-1:0] exp_feed_q[$];
    logic [BW-1:0] xfer_q[$];
    int            xfer_cyc_q[$];
    logic [BW-1:0] out_sb_q[$];

    ascon_stream_driver #(
        .BLOCK_WIDTH(BW),
        .TAG_WIDTH(TW),
        .DEPTH(DEPTH),
        .AW(AW)
`ifdef ASCON_DRV_WATCHDOG_EN
        ,
        .WDOG_WIDTH(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .run_i(run_i), .decrypt_i(decrypt_i), .n_blk_i(n_blk_i), .exp_tag_i(exp_tag_i),
        .core_start_o(core_start_o), .core_data_o(core_data_o),
        .core_data_valid_o(core_data_valid_o), .core_data_ready_i(core_data_ready_i),
        .core_data_i(core_data_i), .core_data_valid_i(core_data_valid_i),
        .core_tag_i(core_tag_i), .core_tag_valid_i(core_tag_valid_i),
        .core_done_i(core_done_i),
        .busy_o(busy_o), .done_o(done_o), .tag_o(tag_o), .auth_ok_o(auth_ok_o),
        .out_cnt_o(out_cnt_o),
`ifdef ASCON_DRV_WATCHDOG_EN
        .err_timeout_o(err_timeout_o),
`endif
        .err_ovf_o(err_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid cycle and every completed handshake on the feed side.
    always @(negedge clk) begin
        if (!rst && core_data_valid_o) begin
            valid_cycles <= valid_cycles + 1;
            if (core_data_ready_i) begin
                xfer_q.push_back(core_data_o);
                xfer_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got hang, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic pulse_run(input logic dec, input logic [AW:0] n, input logic [TW-1:0] t);
        decrypt_i = dec; n_blk_i = n; exp_tag_i = t; run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    task automatic core_beat(input logic dv, input logic [BW-1:0] d,
                             input logic tv, input logic [TW-1:0] t, input logic dn);
        core_data_valid_i = dv; core_data_i = d;
        core_tag_valid_i = tv; core_tag_i = t; core_done_i = dn;
        tick();
        core_data_valid_i = 1'b0; core_tag_valid_i = 1'b0; core_done_i = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_xfers(input int n);
        for (int k = 0; k < 100; k++) begin
            if (xfer_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_chk++;
        if ({core_start_o, core_data_valid_o, busy_o, done_o, auth_ok_o, err_ovf_o} !== 6'b0 ||
            core_data_o !== '0 || tag_o !== '0 || out_cnt_o !== '0 || rd_data_o !== '0)
            $display("FAIL reset_outputs: got start=%b valid=%b busy=%b done=%b tag=%h cnt=%0d, want all 0",
                     core_start_o, core_data_valid_o, busy_o, done_o, tag_o, out_cnt_o);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if (busy_o !== 1'b0) $display("FAIL reset_idle: busy=%b want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_encrypt();
        bit seen;
        logic [BW-1:0] d;
        logic [TW-1:0] t;
        xfer_q.delete(); xfer_cyc_q.delete(); exp_feed_q.delete(); out_sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom};
            host_write(AW'(i), d);
            exp_feed_q.push_back(d);
        end
        core_data_ready_i = 1'b1;
        pulse_run(1'b0, 3, '0);
        wait_xfers(3);
        tick(); tick();
        core_data_ready_i = 1'b0;
        n_chk++;
        if (xfer_q.size() != 3) $display("FAIL enc_xfer_count: got %0d want 3", xfer_q.size());
        else n_pass++;
        for (int i = 0; i < 3 && xfer_q.size() > 0; i++) begin
            n_chk++;
            if (xfer_q[0] !== exp_feed_q[0])
                $display("FAIL enc_feed_%0d: got %h want %h", i, xfer_q[0], exp_feed_q[0]);
            else n_pass++;
            void'(xfer_q.pop_front()); void'(exp_feed_q.pop_front());
        end
        n_chk++;
        if (xfer_cyc_q.size() != 3 || xfer_cyc_q[2] - xfer_cyc_q[0] != 2)
            $display("FAIL enc_consecutive: got %0d transfers not in 3 consecutive cycles, want consecutive",
                     xfer_cyc_q.size());
        else n_pass++;
        d = {$urandom, $urandom}; out_sb_q.push_back(d); core_beat(1'b1, d, 1'b0, '0, 1'b0);
        d = {$urandom, $urandom}; out_sb_q.push_back(d); core_beat(1'b1, d, 1'b0, '0, 1'b0);
        t = {$urandom, $urandom, $urandom, $urandom};
        core_beat(1'b0, '0, 1'b1, t, 1'b1);
        wait_done(seen);
        n_chk++;
        if (!seen) $display("FAIL enc_done: done_o got 0 within bound, want 1");
        else n_pass++;
        n_chk++;
        if (out_cnt_o !== 2 || auth_ok_o !== 1'b0 || tag_o !== t || busy_o !== 1'b0)
            $display("FAIL enc_status: got cnt=%0d auth=%b busy=%b tag=%h, want cnt=2 auth=0 busy=0 tag=%h",
                     out_cnt_o, auth_ok_o, busy_o, tag_o, t);
        else n_pass++;
        tick();
        n_chk++;
        if (done_o !== 1'b0) $display("FAIL enc_done_pulse: got done=%b want 0", done_o);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            rd_addr_i = AW'(i);
            tick();
            n_chk++;
            if (rd_data_o !== out_sb_q[0])
                $display("FAIL enc_readback_%0d: got %h want %h", i, rd_data_o, out_sb_q[0]);
            else n_pass++;
            void'(out_sb_q.pop_front());
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        logic [BW-1:0] exp_b [3];
        xfer_q.delete(); exp_feed_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_b[i] = {$urandom, $urandom};
            host_write(AW'(i), exp_b[i]);
            exp_feed_q.push_back(exp_b[i]);
        end
        core_data_ready_i = 1'b0;
        pulse_run(1'b0, 3, '0);
        tick();
        for (int b = 0; b < 3; b++) begin
            for (int w = 0; w < 5; w++) begin
                n_chk++;
                if (core_data_valid_o !== 1'b1 || core_data_o !== exp_b[b])
                    $display("FAIL bp_hold_%0d_%0d: got valid=%b data=%h, want valid=1 data=%h",
                             b, w, core_data_valid_o, core_data_o, exp_b[b]);
                else n_pass++;
                tick();
            end
            core_data_ready_i = 1'b1;
            tick();
            core_data_ready_i = 1'b0;
        end
        n_chk++;
        if (core_data_valid_o !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", core_data_valid_o);
        else n_pass++;
        n_chk++;
        if (xfer_q.size() != 3) $display("FAIL bp_xfer_count: got %0d want 3", xfer_q.size());
        else n_pass++;
        while (xfer_q.size() > 0 && exp_feed_q.size() > 0) begin
            n_chk++;
            if (xfer_q[0] !== exp_feed_q[0])
                $display("FAIL bp_feed: got %h want %h", xfer_q[0], exp_feed_q[0]);
            else n_pass++;
            void'(xfer_q.pop_front()); void'(exp_feed_q.pop_front());
        end
        core_beat(1'b0, '0, 1'b0, '0, 1'b1);
        wait_done(seen);
        n_chk++;
        if (!seen || out_cnt_o !== 0)
            $display("FAIL bp_done: got seen=%b cnt=%0d, want seen=1 cnt=0", seen, out_cnt_o);
        else n_pass++;
        tick();
    endtask

    // One single-block run whose core returns the given tag strobes with done.
    task automatic dec_run(input logic dec, input logic [TW-1:0] t1, input bit two,
                           input logic [TW-1:0] t2, input logic want_auth, input string nm);
        bit seen;
        logic [BW-1:0] d;
        logic [TW-1:0] last;
        core_data_ready_i = 1'b1;
        pulse_run(dec, 1, KTAG);
        n_chk++;
        if (auth_ok_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL %s_cleared: got auth=%b busy=%b, want auth=0 busy=1", nm, auth_ok_o, busy_o);
        else n_pass++;
        tick(); tick();
        core_data_ready_i = 1'b0;
        d = {$urandom, $urandom};
        out_sb_q.delete(); out_sb_q.push_back(d);
        last = t1;
        if (two) begin
            core_beat(1'b0, '0, 1'b1, t1, 1'b0);
            last = t2;
        end
        core_beat(1'b1, d, 1'b1, last, 1'b1);
        wait_done(seen);
        n_chk++;
        if (!seen || auth_ok_o !== want_auth || tag_o !== last || out_cnt_o !== 1)
            $display("FAIL %s: got seen=%b auth=%b tag=%h cnt=%0d, want seen=1 auth=%b tag=%h cnt=1",
                     nm, seen, auth_ok_o, tag_o, out_cnt_o, want_auth, last);
        else n_pass++;
        rd_addr_i = '0;
        tick();
        tick();
        n_chk++;
        if (rd_data_o !== out_sb_q[0])
            $display("FAIL %s_readback: got %h want %h", nm, rd_data_o, out_sb_q[0]);
        else n_pass++;
        void'(out_sb_q.pop_front());
    endtask

    task automatic test_decrypt();
        host_write('0, {$urandom, $urandom});
        dec_run(1'b1, KTAG, 1'b0, '0, 1'b1, "dec_match");
        dec_run(1'b1, KTAG ^ 128'h1, 1'b0, '0, 1'b0, "dec_bit0");
        dec_run(1'b1, KTAG ^ 128'h1, 1'b1, KTAG, 1'b1, "dec_overwrite_ok");
        dec_run(1'b1, KTAG, 1'b1, KTAG ^ 128'h1, 1'b0, "dec_overwrite_bad");
        dec_run(1'b0, KTAG, 1'b0, '0, 1'b0, "enc_no_auth");
    endtask

    task automatic test_zero_blocks();
        bit seen;
        int vc0;
        vc0 = valid_cycles;
        core_data_ready_i = 1'b1;
        pulse_run(1'b0, 0, '0);
        n_chk++;
        if (core_start_o !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL zero_start: got start=%b busy=%b want 1 1", core_start_o, busy_o);
        else n_pass++;
        tick();
        n_chk++;
        if (core_start_o !== 1'b0 || core_data_valid_o !== 1'b0)
            $display("FAIL zero_wait: got start=%b valid=%b want 0 0", core_start_o, core_data_valid_o);
        else n_pass++;
        repeat (5) tick();
        core_beat(1'b0, '0, 1'b0, '0, 1'b1);
        wait_done(seen);
        n_chk++;
        if (!seen || out_cnt_o !== 0 || valid_cycles != vc0)
            $display("FAIL zero_done: got seen=%b cnt=%0d valid_cycles=%0d, want 1 0 %0d",
                     seen, out_cnt_o, valid_cycles, vc0);
        else n_pass++;
        core_data_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        bit seen;
        logic [BW-1:0] d;
        logic [BW-1:0] k0;
        k0 = {$urandom, $urandom};
        host_write('0, k0);
        out_sb_q.delete();
        pulse_run(1'b0, 0, '0);
        tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = {$urandom, $urandom};
            if (i < DEPTH) out_sb_q.push_back(d);
            core_beat(1'b1, d, 1'b0, '0, 1'b0);
        end
        n_chk++;
        if (out_cnt_o !== DEPTH || err_ovf_o !== 1'b1)
            $display("FAIL ovf_flag: got cnt=%0d ovf=%b want %0d 1", out_cnt_o, err_ovf_o, DEPTH);
        else n_pass++;
        host_write('0, ~k0);
        pulse_run(1'b1, 1, KTAG);
        n_chk++;
        if (out_cnt_o !== DEPTH || err_ovf_o !== 1'b1 || core_start_o !== 1'b0 || busy_o !== 1'b1)
            $display("FAIL busy_ignore: got cnt=%0d ovf=%b start=%b busy=%b, want %0d 1 0 1",
                     out_cnt_o, err_ovf_o, core_start_o, busy_o, DEPTH);
        else n_pass++;
        core_beat(1'b0, '0, 1'b0, '0, 1'b1);
        wait_done(seen);
        n_chk++;
        if (!seen || err_ovf_o !== 1'b1 || out_cnt_o !== DEPTH)
            $display("FAIL ovf_done: got seen=%b ovf=%b cnt=%0d want 1 1 %0d", seen, err_ovf_o, out_cnt_o, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_i = AW'(i);
            tick();
            n_chk++;
            if (rd_data_o !== out_sb_q[0])
                $display("FAIL ovf_readback_%0d: got %h want %h", i, rd_data_o, out_sb_q[0]);
            else n_pass++;
            void'(out_sb_q.pop_front());
        end
        xfer_q.delete();
        core_data_ready_i = 1'b1;
        pulse_run(1'b0, 1, '0);
        n_chk++;
        if (err_ovf_o !== 1'b0 || out_cnt_o !== 0)
            $display("FAIL ovf_rerun_clear: got ovf=%b cnt=%0d want 0 0", err_ovf_o, out_cnt_o);
        else n_pass++;
        wait_xfers(1);
        core_data_ready_i = 1'b0;
        n_chk++;
        if (xfer_q.size() != 1 || xfer_q[0] !== k0)
            $display("FAIL wr_busy_ignored: got %0d xfers first=%h, want 1 xfer %h",
                     xfer_q.size(), (xfer_q.size() > 0) ? xfer_q[0] : '0, k0);
        else n_pass++;
        tick();
        core_beat(1'b0, '0, 1'b0, '0, 1'b1);
        wait_done(seen);
        tick();
    endtask

    task automatic test_reset_mid_feed();
        host_write('0, {$urandom, $urandom});
        host_write(1, {$urandom, $urandom});
        core_data_ready_i = 1'b0;
        pulse_run(1'b1, 2, KTAG);
        tick();
        core_beat(1'b1, 64'hFFFF_0000_FFFF_0000, 1'b1, KTAG, 1'b0);
        rd_addr_i = '0;
        tick();
        n_chk++;
        if (core_data_valid_o !== 1'b1 || out_cnt_o !== 1 || auth_ok_o !== 1'b1)
            $display("FAIL midfeed_pre: got valid=%b cnt=%0d auth=%b want 1 1 1",
                     core_data_valid_o, out_cnt_o, auth_ok_o);
        else n_pass++;
        rst = 1'b1;
        tick();
        n_chk++;
        if ({core_start_o, core_data_valid_o, busy_o, done_o, auth_ok_o, err_ovf_o} !== 6'b0 ||
            core_data_o !== '0 || tag_o !== '0 || out_cnt_o !== '0 || rd_data_o !== '0)
            $display("FAIL midfeed_reset: got valid=%b busy=%b auth=%b cnt=%0d tag=%h rd=%h, want all 0",
                     core_data_valid_o, busy_o, auth_ok_o, out_cnt_o, tag_o, rd_data_o);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++;
        if (busy_o !== 1'b0 || core_data_valid_o !== 1'b0)
            $display("FAIL midfeed_idle: got busy=%b valid=%b want 0 0", busy_o, core_data_valid_o);
        else n_pass++;
    endtask

`ifdef ASCON_DRV_WATCHDOG_EN
    task automatic test_watchdog();
        int waited;
        core_data_ready_i = 1'b0;
        pulse_run(1'b0, 1, '0);
        waited = 0;
        while (!done_o && waited < 40) begin
            tick();
            waited++;
        end
        n_chk++;
        if (!done_o || err_timeout_o !== 1'b1 || waited < 15 || waited > 18)
            $display("FAIL wdog_timeout: got done=%b timeout=%b after %0d cycles, want 1 1 after 15..18",
                     done_o, err_timeout_o, waited);
        else n_pass++;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
        run_i = 1'b0; decrypt_i = 1'b0; n_blk_i = '0; exp_tag_i = '0;
        core_data_ready_i = 1'b0; core_data_i = '0; core_data_valid_i = 1'b0;
        core_tag_i = '0; core_tag_valid_i = 1'b0; core_done_i = 1'b0;
        test_reset();
        test_encrypt();
        test_backpressure();
        test_decrypt();
        test_zero_blocks();
        test_overflow();
        test_reset_mid_feed();
`ifdef ASCON_DRV_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
